// File: rtl/uart_pkg.sv
// Shared types and register map for the byte-wide 8N1 UART.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic REG_DATA     = 1'b0;
    localparam int   ST_RX_AVAIL  = 0;
    localparam int   ST_TX_ACTIVE = 1;

endpackage

// File: rtl/uart_rx.sv
// Serial receiver: 2-flop synchronizer, mid-bit sampling, byte holding register.
// Latency: rx_done pulses in the cycle of the stop-bit sample, about 2 + 9.5 bit periods after the start edge.
// Backpressure: none; a new byte overwrites rx_reg regardless of whether the last one was read.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_done,
    output logic [7:0] rx_reg
);
    import uart_pkg::*;

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_s;
    uart_state_t   state, state_d;
    logic [BW-1:0] baud, baud_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rx_reg  <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            if (rx_done) begin
                rx_reg <= shift;
            end
        end
    end

    always_comb begin
        state_d   = state;
        baud_d    = baud + 1'b1;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        rx_done   = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (baud == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud == BIT_LAST) begin
                    baud_d    = '0;
                    shift_d   = {rx_s, shift[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud == BIT_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    rx_done = rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART on a 68000-style bus: transmitter, bus decode, rx_avail flag; receiver in uart_rx.
// Latency: tx drops one cycle after the write strobe edge; a frame lasts exactly 10 bit periods.
// Backpressure: a write arriving while tx_active is high is dropped; software polls tx_active.
module uart_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    input  logic        addr,
    input  logic        rw,
    input  logic        uds,
    input  logic        lds,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        rx_avail,
    output logic        tx_active,
    input  logic        rx_avail_clear_i
);
    import uart_pkg::*;

    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

    logic          wr_hi, wr_hi_q, wr_clr, tx_start;
    uart_state_t   tx_state, tx_state_d;
    logic [BW-1:0] tx_baud, tx_baud_d;
    logic [2:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          tx_d;
    logic          rx_done;
    logic [7:0]    rx_reg;
    logic [7:0]    status;

    assign wr_hi     = uds & ~rw & (addr == REG_DATA);
    assign wr_clr    = lds & ~rw & (addr == REG_DATA) & data_write[0];
    assign tx_active = (tx_state != IDLE);
    // Edge-detected so a strobe held across several cycles still sends one byte.
    assign tx_start  = wr_hi & ~wr_hi_q & ~tx_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_hi_q  <= 1'b0;
            tx_state <= IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            tx       <= 1'b1;
            rx_avail <= 1'b0;
        end else begin
            wr_hi_q  <= wr_hi;
            tx_state <= tx_state_d;
            tx_baud  <= tx_baud_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx       <= tx_d;
            if (rx_done) begin
                rx_avail <= 1'b1;
            end else if (rx_avail_clear_i || wr_clr) begin
                rx_avail <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_baud_d  = tx_baud + 1'b1;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        case (tx_state)
            IDLE: begin
                tx_baud_d = '0;
                if (tx_start) begin
                    tx_state_d = START;
                    tx_shift_d = data_write[15:8];
                end
            end
            START: begin
                if (tx_baud == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_baud == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b1, tx_shift[7:1]};
                    tx_bit_d   = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state_d = STOP;
                end
            end
            STOP: begin
                if (tx_baud == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        // tx is registered from the next state so the line never glitches.
        case (tx_state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = rx_avail;
        status[ST_TX_ACTIVE] = tx_active;
        data_read            = (addr == REG_DATA) ? {rx_reg, status} : 16'h0000;
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .rx_done(rx_done),
        .rx_reg (rx_reg)
    );

endmodule

// File: tb/tb_uart_core.sv
// Randomized self-checking bench for uart_core against a frame-level reference model.
module tb_uart_core;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic        tx;
    logic        addr = 1'b0;
    logic        rw = 1'b1;
    logic        uds = 1'b0;
    logic        lds = 1'b0;
    logic [15:0] data_write = 16'h0000;
    logic [15:0] data_read;
    logic        rx_avail;
    logic        tx_active;
    logic        rx_avail_clear_i = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  exp_reg = 8'h00;
    logic        exp_avail = 1'b0;
    logic        mon_en = 1'b0;
    logic        seen_avail = 1'b0;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_core #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx_line),
        .tx              (tx),
        .addr            (addr),
        .rw              (rw),
        .uds             (uds),
        .lds             (lds),
        .data_write      (data_write),
        .data_read       (data_read),
        .rx_avail        (rx_avail),
        .tx_active       (tx_active),
        .rx_avail_clear_i(rx_avail_clear_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && rx_avail) seen_avail = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_rx_state(input string tag);
        check({tag, "_avail"}, rx_avail, exp_avail);
        check({tag, "_reg"}, data_read[15:8], exp_reg);
    endtask

    // Send one byte through the bus and compare the whole tx waveform with the ideal frame.
    task automatic tx_frame_check(input logic [7:0] b, input bit busy_write);
        logic [9:0]  f;
        logic [39:0] got, exp;
        int          act, idle;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) exp[i] = f[i / CPB];
        got = '0;
        act = 0;
        rw = 1'b0; uds = 1'b1; data_write = {b, 8'h00};
        for (int i = 0; i < 40; i++) begin
            tick(1);
            got[i] = tx;
            if (tx_active) act++;
            if (i == 1) begin uds = 1'b0; rw = 1'b1; end
            if (busy_write && i == 12) begin rw = 1'b0; uds = 1'b1; data_write = 16'h4200; end
            if (busy_write && i == 14) begin uds = 1'b0; rw = 1'b1; end
        end
        check("tx_frame", got, exp);
        check("tx_active_cycles", act, 40);
        tick(1);
        check("tx_active_end", tx_active, 1'b0);
        idle = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx && !tx_active) idle++;
            tick(1);
        end
        check("tx_single_frame", idle, 30);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            tick(CPB);
        end
        rx_drv = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic lds_write(input logic [15:0] d);
        rw = 1'b0; lds = 1'b1; data_write = d;
        tick(1);
        lds = 1'b0; rw = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bit         err;
        int         w;
        int         sel;

        // Reset
        tick(20);
        check("rst_tx", tx, 1'b1);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_rx_avail", rx_avail, 1'b0);
        check("rst_data_read", data_read, 16'h0000);
        reset = 1'b0;
        tick(2);

        tx_frame_check(8'h41, 1'b0);
        tx_frame_check(8'h41, 1'b1);
        tx_frame_check(8'($urandom), 1'b0);

        // Loopback, back-to-back frames polled via tx_active
        loop_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b = 8'h41 + 8'(k);
            rw = 1'b0; uds = 1'b1; data_write = {b, 8'h00};
            tick(2);
            uds = 1'b0; rw = 1'b1;
            w = 0;
            while (tx_active && w < 200) begin
                tick(1);
                w++;
            end
            check("lb_timeout", w < 200, 1'b1);
            tick(3);
            exp_reg = b; exp_avail = 1'b1;
            check_rx_state("lb");
            check("lb_status_bit", data_read[0], 1'b1);
            if (k == 0) begin
                addr = 1'b1;
                #1;
                check("addr1_read", data_read, 16'h0000);
                addr = 1'b0;
                #1;
            end
            rx_avail_clear_i = 1'b1;
            tick(1);
            rx_avail_clear_i = 1'b0;
            exp_avail = 1'b0;
            check("lb_clear", rx_avail, exp_avail);
        end
        loop_en = 1'b0;
        tick(4);

        // Framing error
        drive_frame(8'h55, 1'b0);
        tick(CPB * 4);
        check_rx_state("frame_err");

        // Start-bit glitch
        rx_drv = 1'b0;
        tick(1);
        rx_drv = 1'b1;
        tick(CPB * 12);
        check_rx_state("glitch");

        // Overrun
        drive_frame(8'h10, 1'b1);
        drive_frame(8'h20, 1'b1);
        exp_reg = 8'h20; exp_avail = 1'b1;
        check_rx_state("overrun");

        // Clear held across the stop sample: the set must still be visible
        rx_avail_clear_i = 1'b1;
        tick(1);
        seen_avail = 1'b0;
        mon_en = 1'b1;
        drive_frame(8'hA5, 1'b1);
        mon_en = 1'b0;
        rx_avail_clear_i = 1'b0;
        tick(1);
        exp_reg = 8'hA5; exp_avail = 1'b0;
        check("set_beats_clear", seen_avail, 1'b1);
        check_rx_state("set_clear_after");

        // Random frames with random clear methods
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            err = ($urandom_range(0, 3) == 0);
            drive_frame(b, !err);
            if (!err) begin
                exp_reg = b;
                exp_avail = 1'b1;
            end
            check_rx_state("rand_rx");
            sel = $urandom_range(0, 3);
            case (sel)
                1: begin
                    rx_avail_clear_i = 1'b1;
                    tick(1);
                    rx_avail_clear_i = 1'b0;
                    exp_avail = 1'b0;
                end
                2: begin
                    lds_write(16'($urandom) | 16'h0001);
                    exp_avail = 1'b0;
                end
                3: lds_write(16'($urandom) & 16'hFFFE);
                default: tick(1);
            endcase
            check("rand_clear", rx_avail, exp_avail);
        end

        // Reset in the middle of a transmit
        rw = 1'b0; uds = 1'b1; data_write = 16'h0F00;
        tick(2);
        uds = 1'b0; rw = 1'b1;
        tick(10);
        check("mid_tx_active", tx_active, 1'b1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_tx_active", tx_active, 1'b0);
        check("mid_rst_data_read", data_read, 16'h0000);
        reset = 1'b0;
        tick(CPB * 12);
        check("post_rst_idle", tx, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Byte-wide 8N1 UART peripheral on the 16-bit 68000-style CPU bus (rw, uds, lds strobes).
- One transmitter and one receiver sharing a fixed bit period.
- Exposes rx_avail and tx_active as direct status outputs for polling or interrupts.
- Sits beside RAM and SPI in the SoC; a second instance serves as a loopback peer in system benches.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be at least 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- tx  out  1  serial output, idle high.
- addr  in  1  register select; only 0 is implemented.
- rw  in  1  1 = read, 0 = write.
- uds  in  1  upper byte strobe (data bits 15:8).
- lds  in  1  lower byte strobe (data bits 7:0).
- data_write  in  16  CPU write data.
- data_read  out  16  CPU read data, combinational from addr and registers.
- rx_avail  out  1  received byte waiting in rx_reg.
- tx_active  out  1  transmitter busy.
- rx_avail_clear_i  in  1  level clear of rx_avail.

Behaviour:
- Reset values:
  - tx = 1, tx_active = 0, rx_avail = 0.
  - rx_reg = 0, tx shift register = all ones.
  - Both state machines go to IDLE.
  - Synchronizer and strobe-edge flops go to 1, 1 and 0.
  - Reset asserted mid-frame aborts the frame immediately; tx returns high the next cycle.
- Write strobe:
  - wr_hi = uds & ~rw & (addr == 0).
  - A transmit starts on the rising edge of wr_hi (registered previous value), so a strobe held for several cycles sends one byte.
  - If wr_hi rises while tx_active = 1, the write is ignored.
- Lower-byte write: lds & ~rw & (addr == 0) with data_write[0] = 1 clears rx_avail.
- Read map, addr 0:
  - data_read[15:8] = rx_reg.
  - data_read[7:0] = {6'b0, tx_active, rx_avail}.
  - addr 1 reads 0.
  - Reads have no side effects.
- TX state machine, states IDLE, START, DATA, STOP:
  - On a start edge: latch data_write[15:8]; tx_active = 1 in the following cycle.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx = 1 for CLKS_PER_BIT cycles.
  - Return to IDLE; tx_active = 0 from the cycle after the stop bit ends.
  - Frame length is exactly 10 × CLKS_PER_BIT cycles.
- RX input: rx passes through a 2-flop synchronizer, giving rx_s.
- RX state machine, states IDLE, START, DATA, STOP:
  - IDLE: wait for rx_s = 0.
  - START: at CLKS_PER_BIT/2 cycles, re-sample rx_s. If 1, treat as a glitch and return to IDLE; otherwise continue.
  - DATA: sample each bit at its mid-point (every CLKS_PER_BIT cycles); shift LSB first.
  - STOP: sample at mid-bit. If 1, load rx_reg and set rx_avail. If 0 (framing error), discard the byte and leave rx_avail unchanged.
  - Return to IDLE in the cycle after the stop sample, so back-to-back frames are accepted.
- rx_avail rules:
  - Cleared by rx_avail_clear_i = 1 (level) or by the lower-byte clear write.
  - A set in the same cycle as a clear wins: rx_avail = 1.
  - Overrun: a new byte overwrites rx_reg and rx_avail stays 1; no error flag.
- Bit counter is 3 bits; wrap from 7 ends DATA.
- Baud counter width is clog2(CLKS_PER_BIT).

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - Register offset constant REG_DATA = 0.
  - Status bit indices ST_RX_AVAIL = 0 and ST_TX_ACTIVE = 1.
- One sub-module, uart_rx: synchronizer, receive state machine and rx_reg.
- Transmitter, bus decode and rx_avail logic stay in uart_core.

Test Plan:
- Reset: hold reset for 20 clk -> tx = 1, tx_active = 0, rx_avail = 0, data_read at addr 0 = 0x0000.
- TX 0x41 with CLKS_PER_BIT = 4 (uds = 1, rw = 0, data_write = 0x4100 held 2 cycles):
  - tx sequence 0,1,0,0,0,0,0,1,0,1, each 4 cycles.
  - tx_active high for 40 cycles.
  - Exactly one frame sent.
- Loopback tx→rx sending 0x41 to 0x45 back-to-back, polling tx_active; after each frame:
  - rx_avail = 1 and data_read[15:8] equals the byte.
  - Clear with rx_avail_clear_i = 1 for 1 cycle -> rx_avail = 0.
- Write while busy: second uds write of 0x4200 during a frame -> ignored; only 0x41 appears on tx.
- Framing error: drive a frame of 0x55 with stop bit 0 -> rx_avail stays 0 and rx_reg unchanged.
- Start glitch and overrun:
  - A 1-cycle low pulse on rx -> no reception.
  - Two frames 0x10 then 0x20 without clearing -> rx_reg = 0x20, rx_avail = 1.
  - Clear and new stop sample in the same cycle -> rx_avail = 1.
